// File: rtl/uart_pkg.sv
// Shared types and limits for the UART autobaud block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

    // Measurement controller states
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_IDLE  = 3'd1,
        WAIT_START = 3'd2,
        MEASURE    = 3'd3,
        CALC       = 3'd4
    } ab_state_t;

    // Shortest accepted 8-bit-time span; anything faster cannot be divided down to a 16x clock
    localparam int MIN_COUNT = 128;
    // Largest divisor the 13-bit baud generator can take
    localparam int BAUD_MAX  = 8191;

    localparam int BAUD_W = 13;
    localparam int FRAC_W = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the async rx line with a falling-edge strobe.
// Latency: STAGES clk to rx_sync; rx_fall is combinational from the last two stages.
// Backpressure: none; free-running sampler.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx,
    output logic rx_sync,
    output logic rx_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw line through the synchronizer chain; idle-high reset avoids a false edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], rx};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rx_sync = sync_q[STAGES-1];
    // High in the cycle the synchronized line first reads 0 after a 1
    assign rx_fall = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/uart_autobaud.sv
// Measures the 0x55 sync character on rx and derives a 16x baud divisor (macro UART_AUTOBAUD_FRACTION_EN selects fractional vs rounded output).
// Latency: valid/error 2 clk after the 5th synchronized falling edge; timeout after 2^CNT_W-1 counts.
// Backpressure: none; arm in any busy state restarts the measurement and drops the partial result.
module uart_autobaud
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rx,
    input  logic              arm,
    output logic [BAUD_W-1:0] baud_val,
    output logic [FRAC_W-1:0] baud_val_fraction,
    output logic              valid,
    output logic              locked,
    output logic              busy,
    output logic              error
);

    localparam int EXT_W = CNT_W + 1;

    ab_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        edge_cnt;
    logic [CNT_W-1:0]  n_q;

    logic              rx_sync;
    logic              rx_fall;

    logic [EXT_W-1:0]  n_ext;
    logic [EXT_W-1:0]  div_full;
    logic [FRAC_W-1:0] frac_calc;
    logic              too_fast;
    logic              too_slow;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx),
        .rx_sync (rx_sync),
        .rx_fall (rx_fall)
    );

    // Divisor from the captured 8-bit-time count; one extra bit so rounding cannot wrap
    always_comb begin
        n_ext = {1'b0, n_q};
`ifdef UART_AUTOBAUD_FRACTION_EN
        div_full  = (n_ext >> 7) - EXT_W'(1);
        frac_calc = n_q[6:4];
`else
        div_full  = ((n_ext + EXT_W'(64)) >> 7) - EXT_W'(1);
        frac_calc = '0;
`endif
        too_fast = (n_ext < EXT_W'(MIN_COUNT));
        too_slow = (div_full > EXT_W'(BAUD_MAX));
    end

    // Measurement FSM with registered status and result outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            cnt               <= '0;
            edge_cnt          <= '0;
            n_q               <= '0;
            baud_val          <= '0;
            baud_val_fraction <= '0;
            valid             <= 1'b0;
            error             <= 1'b0;
            locked            <= 1'b0;
            busy              <= 1'b0;
        end else begin
            valid <= 1'b0;
            error <= 1'b0;
            if (arm) begin
                // Fresh request always wins: partial counts are dropped, nothing is reported
                state    <= WAIT_IDLE;
                cnt      <= '0;
                edge_cnt <= '0;
                busy     <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    WAIT_IDLE: begin
                        // Don't trust a falling edge until the line has been seen idle
                        if (rx_sync) begin
                            state <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        if (rx_fall) begin
                            cnt      <= '0;
                            edge_cnt <= '0;
                            state    <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (cnt == {CNT_W{1'b1}}) begin
                            // Line stuck or far too slow
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                            if (rx_fall) begin
                                if (edge_cnt == 2'd3) begin
                                    // Start-bit edge to this edge is exactly 8 bit times
                                    n_q   <= cnt + CNT_W'(1);
                                    state <= CALC;
                                end else begin
                                    edge_cnt <= edge_cnt + 2'd1;
                                end
                            end
                        end
                    end
                    CALC: begin
                        if (too_fast || too_slow) begin
                            error <= 1'b1;
                        end else begin
                            valid             <= 1'b1;
                            locked            <= 1'b1;
                            baud_val          <= div_full[BAUD_W-1:0];
                            baud_val_fraction <= frac_calc;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
